// File: rtl/pc_unit_pkg.sv
// Shared types and constants for the rysy program-counter unit.
package rysyPkg;

    typedef enum logic [2:0] {
        PC_ALU = 3'd0,
        PC_P4  = 3'd1,
        PC_M4  = 3'd2,
        PC_OLD = 3'd3,
        PC_EPC = 3'd4
    } pc_sel_t;

    typedef enum logic {
        MEM_PC  = 1'b0,
        MEM_ALU = 1'b1
    } mem_sel_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } req_state_t;

    localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VEC  = 32'h0000_0010;

endpackage

// File: rtl/pc_unit_if.sv
// Memory request port: registered address with a valid/ready handshake.
interface pc_unit_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] addr;
    logic            valid;
    logic            ready;

    modport master (
        output addr,
        output valid,
        input  ready
    );

    modport slave (
        input  addr,
        input  valid,
        output ready
    );
endinterface

// File: rtl/pc_unit_bus_req_reg.sv
// Request FSM for the memory port: registers bus address/valid and derives stall.
module bus_req_reg
    import rysyPkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            go,
    input  logic [XLEN-1:0] addr,
    pc_unit_if.master       bus,
    output logic            stall
);

    req_state_t      state_r;
    req_state_t      state_next_s;
    logic [XLEN-1:0] addr_r;
    logic [XLEN-1:0] addr_next_s;

    // State and address registers; reset abandons any in-flight request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            addr_r  <= '0;
        end else begin
            state_r <= state_next_s;
            addr_r  <= addr_next_s;
        end
    end

    // Next state: a ready BUSY cycle can reissue immediately, so there is no bubble.
    always_comb begin
        state_next_s = state_r;
        addr_next_s  = addr_r;
        case (state_r)
            IDLE: begin
                if (go) begin
                    state_next_s = BUSY;
                    addr_next_s  = addr;
                end else begin
                    state_next_s = IDLE;
                end
            end
            BUSY: begin
                if (bus.ready) begin
                    if (go) begin
                        state_next_s = BUSY;
                        addr_next_s  = addr;
                    end else begin
                        state_next_s = IDLE;
                    end
                end else begin
                    state_next_s = BUSY;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    assign bus.addr  = addr_r;
    assign bus.valid = (state_r == BUSY);
    // Combinational so the PC freezes in the same cycle the bus refuses.
    assign stall     = (state_r == BUSY) & ~bus.ready;

endmodule

// File: rtl/pc_unit.sv
// Program counter, next-PC mux and misaligned-target trap for the rysy core.
// Optional feature macro: PC_UNIT_MISALIGN_TRAP_EN (trap on misaligned PC_ALU targets).
module pc_unit
    import rysyPkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DEFAULT_RESET_VEC),
    parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(DEFAULT_TRAP_VEC)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2:0]      pc_sel,
    input  logic            mem_sel,
    input  logic            req,
    input  logic [XLEN-1:0] alu_out,
    pc_unit_if.master       bus,
    output logic            stall,
    output logic [XLEN-1:0] pc,
    output logic            trap,
    output logic [XLEN-1:0] epc,
    output logic [XLEN-1:0] badaddr
);

    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] epc_r;
    logic [XLEN-1:0] badaddr_r;
    logic            trap_r;
    logic [XLEN-1:0] pc_next_s;
    logic [XLEN-1:0] alu_target_s;
    logic [XLEN-1:0] req_addr_s;
    logic            misalign_s;
    logic            trap_take_s;
    logic            advance_s;
    logic            req_go_s;
    logic            stall_s;

    assign advance_s = ~stall_s;

`ifdef PC_UNIT_MISALIGN_TRAP_EN
    assign alu_target_s = alu_out;
    assign misalign_s   = (pc_sel == PC_ALU) && (alu_out[1:0] != 2'b00);
`else
    // Without trapping, jump targets are forced onto a word boundary.
    assign alu_target_s = {alu_out[XLEN-1:2], 2'b00};
    assign misalign_s   = 1'b0;
`endif

    // Next-PC selection; a trap overrides the select and only fires in advance cycles.
    always_comb begin
        pc_next_s   = pc_r;
        trap_take_s = 1'b0;
        if (advance_s) begin
            case (pc_sel)
                PC_ALU:  pc_next_s = alu_target_s;
                PC_P4:   pc_next_s = pc_r + XLEN'(32'd4);
                PC_M4:   pc_next_s = pc_r - XLEN'(32'd4);
                PC_OLD:  pc_next_s = pc_r;
                PC_EPC:  pc_next_s = epc_r;
                default: pc_next_s = pc_r;
            endcase
            if (misalign_s) begin
                trap_take_s = 1'b1;
                pc_next_s   = TRAP_VEC;
            end else begin
                trap_take_s = 1'b0;
            end
        end else begin
            pc_next_s   = pc_r;
            trap_take_s = 1'b0;
        end
    end

    // PC, trap pulse and fault-record registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r      <= RESET_VEC;
            epc_r     <= '0;
            badaddr_r <= '0;
            trap_r    <= 1'b0;
        end else begin
            pc_r   <= pc_next_s;
            trap_r <= trap_take_s;
            if (trap_take_s) begin
                epc_r     <= pc_r;
                badaddr_r <= alu_out;
            end else begin
                epc_r     <= epc_r;
                badaddr_r <= badaddr_r;
            end
        end
    end

    // Request address uses the pre-update PC; a trap cancels the request.
    assign req_addr_s = (mem_sel == MEM_PC) ? pc_r : alu_out;
    assign req_go_s   = req & ~trap_take_s;

    bus_req_reg #(
        .XLEN (XLEN)
    ) u_bus_req_reg (
        .clk   (clk),
        .rst   (rst),
        .go    (req_go_s),
        .addr  (req_addr_s),
        .bus   (bus),
        .stall (stall_s)
    );

    assign stall   = stall_s;
    assign pc      = pc_r;
    assign trap    = trap_r;
    assign epc     = epc_r;
    assign badaddr = badaddr_r;

endmodule

// File: doc/pc_unit.md
# pc_unit

Program-counter and memory-address unit for the rysy core, parametrised in width and reset/trap vectors. It holds the PC, selects the next PC, and issues the memory address over a registered valid/ready request port instead of a bare combinational address. It also stalls PC updates while the bus is busy and optionally traps on misaligned jump targets. It sits between the control FSM/ALU and the memory bus adapter.

## Interface
- XLEN, 32, width of PC, addresses and ALU operand
- RESET_VEC, 0, PC value after reset
- TRAP_VEC, 'h10, PC loaded on a misaligned-target trap
- clk  in  1  core clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- pc_sel  in  3  next-PC select (pc_sel_t: PC_ALU, PC_P4, PC_M4, PC_OLD, PC_EPC)
- mem_sel  in  1  request address source (mem_sel_t: MEM_PC, MEM_ALU)
- req  in  1  control requests a memory access this cycle
- alu_out  in  XLEN  ALU result (jump target or data address)
- bus_addr  out  XLEN  registered request address
- bus_valid  out  1  request pending
- bus_ready  in  1  bus accepts request
- stall  out  1  bus_valid & ~bus_ready
- pc  out  XLEN  current PC
- trap  out  1  one-cycle pulse, misaligned target taken
- epc  out  XLEN  PC of faulting instruction
- badaddr  out  XLEN  offending target address

## Operation
- Advance cycle = stall low. pc_sel, req and trap detection take effect only in advance cycles. Otherwise pc, epc and badaddr hold.
- Next PC: PC_ALU → alu_out; PC_P4 → pc+4; PC_M4 → pc−4; PC_OLD → pc; PC_EPC → epc. Undefined encodings → pc.
- Arithmetic is modulo 2^XLEN. pc−4 at 0 gives 2^XLEN−4; pc+4 at 2^XLEN−4 gives 0.
- Misalignment: a PC_ALU select with alu_out[1:0] ≠ 0 in an advance cycle triggers a trap. The trap does:
  - pc ← TRAP_VEC
  - epc ← pc
  - badaddr ← alu_out
  - trap = 1 for the next cycle
  - req is suppressed that cycle
- Request FSM, states IDLE and BUSY:
  - IDLE, req=1 (not suppressed): bus_addr ← (mem_sel==MEM_PC ? pc : alu_out); go to BUSY.
  - BUSY, bus_ready=0: hold bus_addr and bus_valid.
  - BUSY, bus_ready=1, req=0: go to IDLE.
  - BUSY, bus_ready=1, req=1: reload bus_addr and stay in BUSY (back-to-back issue, no bubble).
- bus_valid = (state==BUSY). Data accesses through MEM_ALU are never checked for alignment.

## Timing
- Reset values: pc=RESET_VEC, bus_addr=0, bus_valid=0, stall=0, trap=0, epc=0, badaddr=0, state IDLE.
- Reset asserted mid-transfer drops bus_valid immediately (asynchronous). The request is abandoned.
- Request latency: req sampled at edge N gives bus_valid high in cycle N+1. Transfer completes at the first edge with bus_ready=1.
- The PC update and the request address in the same cycle both use the pre-update pc.
- stall is combinational from bus_ready and must not be registered.
- Trap has priority over req; pc_sel is the only source of a trap.

## Configuration
- PC_UNIT_MISALIGN_TRAP_EN defined: misaligned PC_ALU targets trap as above.
- Undefined: no trap. PC_ALU loads {alu_out[XLEN-1:2],2'b00}. trap ties to 0, and epc/badaddr stay 0 except through reset.

## Structure
- Shared package rysyPkg holds:
  - pc_sel_t (3-bit enum)
  - mem_sel_t
  - req_state_t (IDLE, BUSY)
  - default TRAP_VEC constant
- Sub-module bus_req_reg holds the request FSM, bus_addr/bus_valid registers and the stall output.
- pc_unit holds the PC, next-PC mux and trap logic.

## Test plan
- Reset, release, then PC_P4 for 3 cycles with bus_ready=1 → pc 0,4,8,12; reset mid-BUSY drops bus_valid the same cycle.
- req with MEM_ALU, alu_out='h200, bus_ready low for 3 cycles → bus_valid high, bus_addr='h200 held, stall=1, pc frozen despite PC_P4; ready high → IDLE.
- req high continuously with bus_ready=1 and MEM_PC → bus_valid stays high, bus_addr tracks pc each cycle with no bubble.
- pc='h40, PC_ALU with alu_out='h102 (macro on) → pc='h10, epc='h40, badaddr='h102, trap pulse, no request issued; PC_EPC afterwards → pc='h40.
- Same stimulus with the macro off → pc='h100, trap=0.
- pc=0 with PC_M4 → pc='hFFFFFFFC; PC_P4 → pc=0.
